// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, imem req/gnt/rvalid requests, and a credit-gated
// instruction buffer feeding decode. Redirects flush the buffer and drop in-flight responses.
//
// state | meaning
// BOOT  | first cycle after reset, no requests, redirects ignored
// RUN   | fetching; responses are pushed into the buffer
// FLUSH | draining responses issued before a redirect, data discarded
module fetch_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        id_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic          grant;
  logic          push;
  logic          pop;
  logic          redirect_act;

  // Credit: every outstanding request already owns a free buffer slot.
  assign occupancy        = {1'b0, outstanding} + {1'b0, count};
  assign target           = redirect_pc_i & ~32'd3;
  assign redirect_act     = redirect_i & (state != BOOT);
  assign imem_req_o       = (state == RUN) & ~redirect_i & (occupancy < DEPTH_W);
  assign imem_addr_o      = fetch_pc;
  assign grant            = imem_req_o & imem_gnt_i;
  assign push             = imem_rvalid_i & (state == RUN) & ~redirect_i;
  assign valid_o          = (count != '0);
  assign pop              = valid_o & id_ready_i & ~redirect_act;
  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);
  assign instruction_o    = valid_o ? buf_instr[rd_ptr] : NOP_INSTR;
  assign pc_o             = valid_o ? buf_pc[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (redirect_i) state <= (outstanding_next != '0) ? FLUSH : RUN;
        FLUSH:   state <= (outstanding_next != '0) ? FLUSH : RUN;
        default: state <= BOOT;
      endcase
      if (redirect_act) begin
        fetch_pc <= target;
        resp_pc  <= target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer payload needs no reset; the head is only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata_i;
      buf_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: acts as instruction memory and decode, and checks every cycle
// against a transaction-level model (pending-request queue, buffered-word count, expected PCs).
module tb_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instruction_o, pc_o;
  logic        valid_o, id_ready_i;

  fetch_stage #(.BOOT_ADDR(32'h0), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .valid_o(valid_o), .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: granted-but-unanswered addresses, words sitting in the buffer, stale responses to drop.
  logic [31:0] pend_q[$];
  int          buffered;
  int          stale;
  bit          booted;
  logic [31:0] exp_fetch, exp_out_pc;

  logic        obs_valid, obs_req, exp_valid, exp_req, granted;
  logic [31:0] obs_pc, obs_instr, obs_addr, exp_pc, exp_instr, exp_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    buffered   = 0;
    stale      = 0;
    booted     = 1'b0;
    exp_fetch  = 32'h0;
    exp_out_pc = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: sample outputs, drive memory/decode/redirect, advance the model. Entered at negedge.
  task automatic cycle(input bit g, input bit rv_en, input bit rdy, input bit redir,
                       input logic [31:0] tgt);
    bit rsp, redir_eff;
    obs_valid = valid_o; obs_pc = pc_o; obs_instr = instruction_o;
    exp_valid = (buffered > 0);
    exp_pc    = exp_valid ? exp_out_pc : 32'h0;
    exp_instr = exp_valid ? mem_word(exp_out_pc) : NOP;
    rsp = rv_en && (pend_q.size() > 0);
    imem_rvalid_i = rsp;
    imem_rdata_i  = rsp ? mem_word(pend_q[0]) : $urandom;
    imem_gnt_i = g; id_ready_i = rdy; redirect_i = redir; redirect_pc_i = tgt;
    #1;
    obs_req = imem_req_o; obs_addr = imem_addr_o;
    exp_req  = booted && (stale == 0) && !redir && (pend_q.size() + buffered < DEPTH);
    exp_addr = exp_fetch;
    granted  = obs_req && g;
    redir_eff = redir && booted;
    if (rsp) begin
      void'(pend_q.pop_front());
      if (!redir_eff) begin
        if (stale > 0) stale--;
        else buffered++;
      end
    end
    if (exp_valid && rdy && !redir_eff) begin
      buffered--;
      exp_out_pc += 32'd4;
    end
    if (granted) begin
      pend_q.push_back(obs_addr);
      exp_fetch += 32'd4;
    end
    if (redir_eff) begin
      buffered   = 0;
      stale      = pend_q.size();
      exp_fetch  = tgt & ~32'd3;
      exp_out_pc = tgt & ~32'd3;
    end
    booted = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    redirect_i = 1'b1; redirect_pc_i = 32'h40; id_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instruction_o, NOP); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_o); end
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int n_valid = 0;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      cycle(1'b1, 1'b1, 1'b1, c == 0, 32'h0000_0040);  // redirect during BOOT must be ignored
      checks++; if (obs_req !== exp_req) begin errors++; $display("FAIL stream_req c%0d: got %b want %b", c, obs_req, exp_req); end
      if (exp_req) begin
        checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h want %h", obs_addr, exp_addr); end
      end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL stream_valid c%0d: got %b want %b", c, obs_valid, exp_valid); end
      checks++; if (obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL stream_data: got %h/%h want %h/%h", obs_pc, obs_instr, exp_pc, exp_instr); end
      if (obs_valid === 1'b1) begin
        n_valid++;
        if (first_valid < 0) first_valid = c;
      end
    end
    // cycle 0 is BOOT, so the first word appears in the fourth cycle after release
    checks++; if (first_valid != 3) begin errors++; $display("FAIL stream_latency: got %0d want 3", first_valid); end
    checks++; if (n_valid != 13) begin errors++; $display("FAIL stream_rate: got %0d want 13", n_valid); end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    int nv = 0;
    bit saw_req = 1'b0;
    logic [31:0] pcs [4];
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (granted) grants++;
      checks++; if (obs_req !== exp_req) begin errors++; $display("FAIL bp_req c%0d: got %b want %b", c, obs_req, exp_req); end
    end
    checks++; if (grants != 4) begin errors++; $display("FAIL bp_grants: got %0d want 4", grants); end
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL bp_stall_req: got %b want 0", obs_req); end
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_req === 1'b1) saw_req = 1'b1;
      if (obs_valid === 1'b1 && nv < 4) begin pcs[nv] = obs_pc; nv++; end
      checks++; if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL bp_drain c%0d: got %b %h %h want %b %h %h", c, obs_valid, obs_pc, obs_instr, exp_valid, exp_pc, exp_instr); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (pcs[k] !== 32'(k * 4)) begin errors++; $display("FAIL bp_order %0d: got %h want %h", k, pcs[k], 32'(k * 4)); end
    end
    checks++; if (!saw_req) begin errors++; $display("FAIL bp_resume: got 0 want 1"); end
  endtask

  task automatic test_redirect_flush();
    int first_req = -1;
    bit got_valid = 1'b0;
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL rf_req_redirect: got %b want 0", obs_req); end
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, c >= 2, 1'b1, 1'b0, 32'h0);
      if (obs_req === 1'b1 && first_req < 0) begin
        first_req = c;
        checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL rf_addr: got %h want 00000100", obs_addr); end
      end
      if (obs_valid === 1'b1 && !got_valid) begin
        got_valid = 1'b1;
        checks++; if (obs_pc !== 32'h100 || obs_instr !== mem_word(32'h100)) begin
          errors++; $display("FAIL rf_first_valid: got %h/%h want 00000100/%h", obs_pc, obs_instr, mem_word(32'h100)); end
      end
      checks++; if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL rf_stream c%0d: got %b %h want %b %h", c, obs_valid, obs_pc, exp_valid, exp_pc); end
    end
    checks++; if (first_req != 4) begin errors++; $display("FAIL rf_flush_len: got %0d want 4", first_req); end
    checks++; if (!got_valid) begin errors++; $display("FAIL rf_no_valid: got 0 want 1"); end
  endtask

  task automatic test_redirect_rvalid();
    apply_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL rr_pre_valid: got %b want 1", obs_valid); end
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL rr_req_redirect: got %b want 0", obs_req); end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
      errors++; $display("FAIL rr_req_target: got %b %h want 1 00000200", obs_req, obs_addr); end
    checks++; if (obs_valid !== 1'b0 || obs_instr !== NOP || obs_pc !== 32'h0) begin
      errors++; $display("FAIL rr_empty: got %b %h %h want 0 %h 0", obs_valid, obs_instr, obs_pc, NOP); end
  endtask

  task automatic test_wrap();
    int ng = 0;
    bit saw_wrap = 1'b0;
    logic [31:0] last_pc = 32'h0;
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (granted) begin
        if (ng == 2) begin
          checks++; if (obs_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", obs_addr); end
        end
        ng++;
      end
      if (obs_valid === 1'b1) begin
        if (last_pc === 32'hFFFF_FFFC && obs_pc === 32'h0) saw_wrap = 1'b1;
        last_pc = obs_pc;
      end
      checks++; if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL wrap_stream c%0d: got %b %h want %b %h", c, obs_valid, obs_pc, exp_valid, exp_pc); end
    end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_tag: got 0 want 1"); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] first_addr = 32'hFFFF_FFFF;
    apply_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL mr_loaded: got %b want 1", obs_valid); end
    rst = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; id_ready_i = 1'b1; redirect_i = 1'b0;
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", valid_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mr_req: got %b want 0", imem_req_o); end
    checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL mr_instr: got %h want %h", instruction_o, NOP); end
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (granted && first_addr === 32'hFFFF_FFFF) first_addr = obs_addr;
      checks++; if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++; $display("FAIL mr_stream c%0d: got %b %h want %b %h", c, obs_valid, obs_pc, exp_valid, exp_pc); end
    end
    checks++; if (first_addr !== 32'h0) begin errors++; $display("FAIL mr_restart: got %h want 00000000", first_addr); end
  endtask

  task automatic test_random();
    bit g, rv, rdy, redir;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      g     = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = booted && ($urandom_range(0, 19) == 0);
      cycle(g, rv, rdy, redir, $urandom);
      checks++; if (obs_req !== exp_req) begin errors++; $display("FAIL rnd_req i%0d: got %b want %b", i, obs_req, exp_req); end
      if (exp_req) begin
        checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr i%0d: got %h want %h", i, obs_addr, exp_addr); end
      end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid i%0d: got %b want %b", i, obs_valid, exp_valid); end
      checks++; if (obs_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc i%0d: got %h want %h", i, obs_pc, exp_pc); end
      checks++; if (obs_instr !== exp_instr) begin errors++; $display("FAIL rnd_instr i%0d: got %h want %h", i, obs_instr, exp_instr); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
